// File: rtl/bindu_bus_if.sv
// Bindu broadcast bus bundle: cluster request/kill lines, sync pulse, beat qualifiers and
// the scheduler's grant outputs.
interface bindu_bus_if #(
    parameter int NUM_REQ = 9,
    parameter int CNT_W   = 8
);
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] kill;
    logic               global_sync;
    logic               bus_valid;
    logic               bus_last;
    logic [NUM_REQ-1:0] grant;
    logic [3:0]         grant_id;
    logic               bus_busy;
    logic [CNT_W-1:0]   beat_count;
    logic               burst_cut;

    // Scheduler side
    modport master (
        input  req, kill, global_sync, bus_valid, bus_last,
        output grant, grant_id, bus_busy, beat_count, burst_cut
    );

    // Cluster side
    modport slave (
        output req, kill, global_sync, bus_valid, bus_last,
        input  grant, grant_id, bus_busy, beat_count, burst_cut
    );
endinterface

// File: rtl/bindu_bus_scheduler.sv
// Burst-based round-robin owner selection for the shared Bindu broadcast bus, with a
// guard window after each global Om sync during which nobody owns the bus.
module bindu_bus_scheduler #(
    parameter int NUM_REQ    = 9,
    parameter int MAX_BURST  = 16,
    parameter int SYNC_GUARD = 4,
    parameter int CNT_W      = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    bindu_bus_if.master bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [NUM_REQ-1:0] ONE_HOT0   = {{(NUM_REQ-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   GUARD_LOAD = CNT_W'(SYNC_GUARD - 1);
    localparam logic [CNT_W-1:0]   CAP        = CNT_W'(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GUARD = 2'd2
    } state_t;

    state_t             state_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [3:0]         grant_id_q;
    logic               bus_busy_q;
    logic [CNT_W-1:0]   beat_q;
    logic               burst_cut_q;
    logic [3:0]         ptr_q;
    logic               sync_pending_q;
    logic [CNT_W-1:0]   guard_cnt_q;

    logic [NUM_REQ-1:0] cand;
    logic [4:0]         pos;
    logic               found;
    logic [3:0]         win;

    logic               owner_kill;
    logic               owner_req;
    logic [CNT_W-1:0]   beat_next;
    logic               is_last;
    logic               is_cap;
    logic               do_exit;
    logic               cut_only;

    assign cand = bus.req & ~bus.kill;

    // Round-robin search starting just after the last owner, wrapping at NUM_REQ.
    always_comb begin
        found = 1'b0;
        win   = '0;
        pos   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            pos = {1'b0, ptr_q} + 5'(i);
            if (pos >= 5'(NUM_REQ)) begin
                pos = pos - 5'(NUM_REQ);
            end
            if (!found && cand[pos[IDX_W-1:0]]) begin
                found = 1'b1;
                win   = pos[3:0];
            end
        end
    end

    assign owner_kill = |(bus.kill & grant_q);
    assign owner_req  = |(bus.req & grant_q);
    assign beat_next  = beat_q + CNT_W'(1);
    assign is_last    = bus.bus_valid & bus.bus_last;
    assign is_cap     = bus.bus_valid & (beat_next == CAP);
    assign do_exit    = owner_kill | is_last | is_cap | ~owner_req;
    // Kill and last outrank the cap, so the cut flag only marks a pure cap exit.
    assign cut_only   = is_cap & ~owner_kill & ~is_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            grant_q        <= '0;
            grant_id_q     <= '0;
            bus_busy_q     <= 1'b0;
            beat_q         <= '0;
            burst_cut_q    <= 1'b0;
            ptr_q          <= 4'(NUM_REQ - 1);
            sync_pending_q <= 1'b0;
            guard_cnt_q    <= '0;
        end else begin
            burst_cut_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.global_sync) begin
                        state_q     <= GUARD;
                        guard_cnt_q <= GUARD_LOAD;
                    end else if (found) begin
                        state_q    <= GRANT;
                        grant_q    <= ONE_HOT0 << win;
                        grant_id_q <= win;
                        bus_busy_q <= 1'b1;
                        beat_q     <= '0;
                    end
                end
                GRANT: begin
                    if (bus.bus_valid) begin
                        beat_q <= beat_next;
                    end
                    if (do_exit) begin
                        grant_q     <= '0;
                        bus_busy_q  <= 1'b0;
                        ptr_q       <= grant_id_q;
                        burst_cut_q <= cut_only;
                        if (sync_pending_q || bus.global_sync) begin
                            state_q     <= GUARD;
                            guard_cnt_q <= GUARD_LOAD;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else if (bus.global_sync) begin
                        // Sync during a burst is deferred until the owner releases.
                        sync_pending_q <= 1'b1;
                    end
                end
                GUARD: begin
                    if (bus.global_sync) begin
                        guard_cnt_q <= GUARD_LOAD;
                    end else if (guard_cnt_q == '0) begin
                        state_q        <= IDLE;
                        sync_pending_q <= 1'b0;
                    end else begin
                        guard_cnt_q <= guard_cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

    assign bus.grant      = grant_q;
    assign bus.grant_id   = grant_id_q;
    assign bus.bus_busy   = bus_busy_q;
    assign bus.beat_count = beat_q;
    assign bus.burst_cut  = burst_cut_q;

endmodule

// File: doc/bindu_bus_scheduler.md
# bindu_bus_scheduler

Round-robin scheduler that shares the single Bindu broadcast bus among the nine Trikona clusters of the Sri-NoC. Grants are burst-based: the owner keeps the bus until it signals its last beat, drops its request, is dissolved, or hits the burst cap. Global Om sync pulses open a guard window in which no cluster holds the bus. The scheduler sits between the cluster request lines and the broadcast mux select inside the Bindu.

## Interface
Parameters:
- NUM_REQ, 9, number of requesting clusters (2..16)
- MAX_BURST, 16, maximum beats per grant (1..2^CNT_W-1)
- SYNC_GUARD, 4, idle cycles enforced after a global sync (≥1)
- CNT_W, 8, width of the beat and guard counters

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req  in  NUM_REQ  per-cluster bus request, level
- kill  in  NUM_REQ  per-cluster dissolution command; masks the request and revokes an active grant
- global_sync  in  1  Om sync pulse
- bus_valid  in  1  owner drives a beat this cycle; ignored unless in GRANT
- bus_last  in  1  qualifies bus_valid as the final beat of the burst
- grant  out  NUM_REQ  one-hot registered grant; all-zero when no owner
- grant_id  out  4  index of the current or most recent owner
- bus_busy  out  1  high while in GRANT
- beat_count  out  CNT_W  beats accepted in the current burst
- burst_cut  out  1  one-cycle pulse when a grant ends on MAX_BURST

## Operation
- States: IDLE, GRANT, GUARD. Internal: ptr (last owner), sync_pending, guard_cnt.
- Reset values: state=IDLE, grant=0, grant_id=0, bus_busy=0, beat_count=0, burst_cut=0, ptr=NUM_REQ-1, sync_pending=0, guard_cnt=0.
- IDLE:
  - global_sync=1 → GUARD. Sync wins over simultaneous requests.
  - Otherwise, if any of (req & ~kill) is set → pick the first such index searching (ptr+1) mod NUM_REQ upward with wrap. Set grant one-hot, grant_id=winner, beat_count=0, go to GRANT.
- GRANT, owner o. Each cycle:
  - bus_valid=1 → beat_count+1.
  - Exit when any of these holds:
    - bus_valid & bus_last
    - bus_valid and beat_count+1 == MAX_BURST; burst_cut pulses on the exit edge
    - kill[o]
    - req[o]=0
  - On exit: grant=0, bus_busy=0, ptr=o, beat_count held until the next grant. Next state is GUARD if sync_pending or global_sync this cycle, else IDLE.
  - global_sync while in GRANT without exit → set sync_pending. The burst is not interrupted.
- GUARD:
  - grant=0. guard_cnt loads SYNC_GUARD-1 on entry and decrements.
  - At 0 → IDLE and clear sync_pending.
  - global_sync during GUARD reloads guard_cnt to SYNC_GUARD-1.
- Requests from other clusters during GRANT are ignored (no preemption).
- Fairness: a continuously requesting cluster waits at most NUM_REQ-1 bursts.

## Timing
- Arbitration latency: request seen in IDLE at edge t → grant high after edge t+1.
- Release: the exit condition seen at edge t → grant low after edge t+1.
- One mandatory IDLE cycle separates consecutive grants. Back-to-back grant is never permitted.
- Guard duration: exactly SYNC_GUARD cycles with grant=0, then one IDLE cycle before the next grant.
- kill[o] revokes within one edge, same as release. Exit priority when several conditions coincide: kill, then last, then cap, then drop. Only a cap-only exit asserts burst_cut.
- Asynchronous reset mid-burst clears all outputs immediately. The first grant after reset goes to the lowest requesting index.
- grant is always one-hot or zero and never changes except on the IDLE→GRANT and GRANT→exit edges.

## Test plan
- Reset, then req=9'h005 at t → grant=9'h001 at t+1, grant_id=0. Three beats with last on the third → grant=0, one IDLE cycle, then grant=9'h004, grant_id=2.
- req=9'h1FF held, every burst one beat with last → grant_id sequence 0,1,2,…,8,0. Each grant lasts one cycle and is separated by one IDLE cycle.
- Owner 3, bus_valid=1 every cycle, never last, MAX_BURST=16 → beat_count reaches 16, burst_cut pulses once, grant drops. req[4]=1 → grant_id=4 next.
- global_sync mid-burst of owner 1 → burst runs to last, then 4 GUARD cycles with grant=0 despite req=9'h1FF, then IDLE, then grant_id=2. Sync and req together in IDLE → GUARD with no grant.
- kill[5] asserted during owner 5's burst → grant=0 next edge. req[5]=1 with kill[5]=1 → cluster 5 never granted; others rotate past it.
- rst_n low mid-burst → grant, bus_busy, beat_count go to 0 asynchronously. After release with req=9'h180 → grant_id=7.
